ht_out_fifo_reader: RTL and testbench
=====================================

Name: ht_out_fifo_reader

Overview:
- Output-side companion to the Hilbert-transform input FIFO/filter path.
- Consumes the filter's quadrature output `q_in` and the raw input sample `x_in`. Delays `x_in` by the filter group delay so the in-phase (I) and quadrature (Q) samples are time-aligned.
- Buffers aligned I/Q pairs in a circular FIFO.
- Drains the pairs to downstream logic over a valid/ready handshake.

Parameters:
- DW, 16, sample width of `x_in`, `q_in`, `out_i`, `out_q` (two's complement).
- DEPTH, 16, FIFO depth in I/Q pairs; must be a power of 2, at least 2.
- GD, 15, Hilbert filter group delay in valid input samples (i.e. (TAPS-1)/2); at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_cnt  in  1  asynchronous, active-low reset.
- x_in  in  DW  raw input sample, same sample that was fed to the Hilbert filter.
- q_in  in  DW  Hilbert filter output for the current sample slot.
- in_valid  in  1  `x_in`/`q_in` are valid this cycle; there is no backpressure to the filter.
- out_i  out  DW  head-of-FIFO in-phase sample.
- out_q  out  DW  head-of-FIFO quadrature sample.
- out_valid  out  1  FIFO non-empty; `out_i`/`out_q` are valid.
- out_ready  in  1  downstream accepts the head pair.
- count  out  $clog2(DEPTH)+1  number of pairs stored.
- overflow  out  1  sticky flag: an aligned pair was dropped because the FIFO was full.
- clr_ovf  in  1  clears `overflow`.

Behaviour:
- Reset (`rst_cnt`=0, asynchronous):
  - Pointers, `count`, prime counter, delay line, `overflow` all 0.
  - `out_valid`=0; `out_i`/`out_q` read as 0.
  - Reset mid-operation discards all buffered pairs and restarts priming.
- Alignment delay line:
  - GD-stage shift register of `x_in`; advances only on `in_valid`=1.
  - `xd` = `x_in` from GD valid samples earlier.
- Priming:
  - Counter `pc`, 0..GD, increments on each `in_valid` while `pc`<GD.
  - While `pc`<GD, valid inputs only shift the delay line; no write occurs.
  - Once `pc`==GD, each `in_valid` issues a write request of pair {`xd`, `q_in`}.
  - `xd` here is the delay-line output before this cycle's shift.
- Push/pop conditions:
  - push_req = `in_valid` & (`pc`==GD).
  - pop = `out_valid` & `out_ready`.
  - push = push_req & ((`count`<DEPTH) | pop): a simultaneous pop frees a slot when full.
- FIFO is first-word-fall-through:
  - `out_i`/`out_q` = mem[rd_ptr], combinational read.
  - `out_valid` = (`count`!=0).
- Latency: a pair pushed at edge N is visible at the outputs with `out_valid`=1 after edge N, provided the FIFO was empty. Total latency from a sample's `x_in` to its `out_i` is GD valid samples plus 1 clock.
- Pointer updates:
  - push: write mem[wr_ptr], then wr_ptr+1.
  - pop: rd_ptr+1.
  - Both pointers wrap modulo DEPTH (natural binary wrap).
- `count` update:
  - +1 on push only; −1 on pop only.
  - Unchanged on push & pop together, or on neither.
- Empty:
  - `out_ready` is ignored while `out_valid`=0.
  - A push into an empty FIFO is not popped in the same cycle.
- Full:
  - push_req & `count`==DEPTH & !pop: the pair is dropped, pointers and `count` are unchanged, and `overflow` is set.
  - The delay line and `pc` still advance.
- `overflow`:
  - Set as above; cleared by `clr_ovf`=1.
  - If set and clear happen in the same cycle, set wins.
- Downstream handshake rule: once `out_valid`=1, `out_i`/`out_q` hold stable until popped.
- Arithmetic: no arithmetic on samples; values pass bit-exact. `count` never exceeds DEPTH.

Test Plan:
- Test 1, reset and priming: GD=3, DEPTH=4. Apply `in_valid` with `x_in`=1,2,3,4,5, `q_in`=10,20,30,40,50, `out_ready`=0.
  - No write for the first 3 samples.
  - Then pairs {1,40} and {2,50} are stored; `count`=2; head `out_i`=1, `out_q`=40.
- Test 2, gap tolerance: same as Test 1 but with `in_valid` deasserted for random cycles between samples → identical stored pairs; `count` unchanged during gaps.
- Test 3, drain and wrap: DEPTH=4. Push 10 aligned pairs with `out_ready`=1 held continuously.
  - Outputs appear in order with no loss and no overflow.
  - Pointers wrap at least twice; `count` ≤1 throughout.
- Test 4, full/overflow: fill to `count`=4 with `out_ready`=0, then push one more.
  - That pair is dropped; `count`=4; `overflow`=1.
  - Next, push with `out_ready`=1 in the same cycle → accepted; `count` stays 4; `overflow` stays 1.
  - Then `clr_ovf` pulse → `overflow`=0.
- Test 5, set/clear collision: assert `clr_ovf` in the same cycle as a dropped push → `overflow`=1.
- Test 6, reset mid-stream: `count`=3 and `pc`=GD, then pulse `rst_cnt` low asynchronously between edges.
  - Immediately `out_valid`=0 and `count`=0.
  - After release, the first GD samples are again not written.

Source files
------------

// File: rtl/ht_out_fifo_reader_if.sv
// Valid/ready stream carrying time-aligned I/Q pairs out of the Hilbert output FIFO.
// The master drives the head pair and valid; the slave drives ready.
interface ht_out_fifo_reader_if #(
    parameter int unsigned DW = 16
);
    logic [DW-1:0] out_i;
    logic [DW-1:0] out_q;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_i,
        output out_q,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_i,
        input  out_q,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ht_out_fifo_reader.sv
// Aligns raw samples with Hilbert filter output by the filter group delay and buffers
// the resulting I/Q pairs in a first-word-fall-through FIFO drained over valid/ready.
module ht_out_fifo_reader #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned GD    = 15
) (
    input  logic                     clk,
    input  logic                     rst_cnt,
    input  logic [DW-1:0]            x_in,
    input  logic [DW-1:0]            q_in,
    input  logic                     in_valid,
    ht_out_fifo_reader_if.master     dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned PCW = $clog2(GD + 1);

    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [PCW-1:0] GD_C    = PCW'(GD);

    logic [DW-1:0]   dly [GD];
    logic [PCW-1:0]  pc;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [2*DW-1:0] mem [DEPTH];
    logic [2*DW-1:0] head;

    logic xd_unused;
    logic [DW-1:0] xd;
    logic primed;
    logic push_req;
    logic pop;
    logic full;
    logic push;
    logic drop;

    assign xd        = dly[GD-1];
    assign xd_unused = 1'b0;
    assign primed    = (pc == GD_C);
    assign push_req  = in_valid & primed;
    assign pop       = dout.out_valid & dout.out_ready;
    assign full      = (count == DEPTH_C);
    // A pop in the same cycle frees the slot the push needs when full.
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk or negedge rst_cnt) begin
        if (!rst_cnt) begin
            pc       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < int'(GD); k++) begin
                dly[k] <= '0;
            end
        end else begin
            if (in_valid) begin
                dly[0] <= x_in;
                for (int k = 1; k < int'(GD); k++) begin
                    dly[k] <= dly[k-1];
                end
                if (!primed) begin
                    pc <= pc + PCW'(1);
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Set has priority over a coincident clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset; out_valid gates the read data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {xd, q_in};
        end
    end

    always_comb begin
        head           = mem[rd_ptr];
        dout.out_valid = (count != '0);
        dout.out_i     = '0;
        dout.out_q     = '0;
        if (dout.out_valid) begin
            dout.out_i = head[2*DW-1:DW];
            dout.out_q = head[DW-1:0];
        end
    end

endmodule

// File: tb/tb_ht_out_fifo_reader.sv
// Scoreboard bench for ht_out_fifo_reader (GD=3, DEPTH=4): directed stimulus pushes
// hand-computed I/Q pairs; a negedge monitor checks every accepted output pair.
module tb_ht_out_fifo_reader;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned GD    = 3;

    logic          clk;
    logic          rst_cnt;
    logic [DW-1:0] x_in;
    logic [DW-1:0] q_in;
    logic          in_valid;
    logic [2:0]    count;
    logic          overflow;
    logic          clr_ovf;

    ht_out_fifo_reader_if #(.DW(DW)) dif ();

    ht_out_fifo_reader #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .GD    (GD)
    ) dut (
        .clk      (clk),
        .rst_cnt  (rst_cnt),
        .x_in     (x_in),
        .q_in     (q_in),
        .in_valid (in_valid),
        .dout     (dif),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted head pair must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst_cnt && dif.out_valid && dif.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h%0h expected nothing",
                         dif.out_i, dif.out_q);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({dif.out_i, dif.out_q} !== e) begin
                    errors++;
                    $display("FAIL pop_pair: got %0h expected %0h",
                             {dif.out_i, dif.out_q}, e);
                end
            end
        end
    end

    function automatic logic [15:0] xs(input int k);
        return 16'(16'h0100 + k);
    endfunction

    function automatic logic [15:0] qs(input int k);
        return 16'(16'h0200 + k);
    endfunction

    // Drive one cycle of inputs; they are consumed at the next rising edge.
    task automatic smp(input logic v, input logic [15:0] x, input logic [15:0] q,
                       input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        in_valid      = v;
        x_in          = x;
        q_in          = q;
        dif.out_ready = rdy;
        clr_ovf       = clr;
    endtask

    task automatic settle(input logic rdy);
        smp(1'b0, 16'h0, 16'h0, rdy, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_cnt       = 1'b0;
        in_valid      = 1'b0;
        clr_ovf       = 1'b0;
        dif.out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_i", 32'(dif.out_i), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_cnt = 1'b1;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        dif.out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (count == 3'd0) break;
        end
        chk("drain_done", 32'(count), 32'd0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        dif.out_ready = 1'b0;
    endtask

    initial begin
        rst_cnt       = 1'b0;
        in_valid      = 1'b0;
        x_in          = '0;
        q_in          = '0;
        clr_ovf       = 1'b0;
        dif.out_ready = 1'b0;

        // Test 1: priming and first aligned pairs.
        do_reset();
        smp(1'b1, 16'd1, 16'd10, 1'b0, 1'b0);
        smp(1'b1, 16'd2, 16'd20, 1'b0, 1'b0);
        smp(1'b1, 16'd3, 16'd30, 1'b0, 1'b0);
        settle(1'b0);
        chk("t1_primed_count", 32'(count), 32'd0);
        smp(1'b1, 16'd4, 16'd40, 1'b0, 1'b0);
        exp_q.push_back({16'd1, 16'd40});
        smp(1'b1, 16'd5, 16'd50, 1'b0, 1'b0);
        exp_q.push_back({16'd2, 16'd50});
        settle(1'b0);
        chk("t1_count", 32'(count), 32'd2);
        chk("t1_head_i", 32'(dif.out_i), 32'd1);
        chk("t1_head_q", 32'(dif.out_q), 32'd40);
        drain();

        // Test 2: same vectors with random gaps between valid samples.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            int exp_cnt;
            smp(1'b1, 16'(k), 16'(10 * k), 1'b0, 1'b0);
            if (k >= 4) exp_q.push_back({16'(k - 3), 16'(10 * k)});
            exp_cnt = (k >= 4) ? k - 3 : 0;
            for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
                settle(1'b0);
                chk("t2_gap_count", 32'(count), 32'(exp_cnt));
            end
        end
        chk("t2_head_i", 32'(dif.out_i), 32'd1);
        chk("t2_head_q", 32'(dif.out_q), 32'd40);
        drain();

        // Test 3: continuous drain, ten pairs, pointers wrap twice.
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            smp(1'b1, 16'(16'd300 + k), 16'(16'd400 + k), 1'b1, 1'b0);
            if (k >= 4) exp_q.push_back({16'(16'd300 + k - 3), 16'(16'd400 + k)});
            @(negedge clk);
            chk("t3_count_le1", 32'(count <= 3'd1), 32'd1);
        end
        settle(1'b1);
        chk("t3_count_le1", 32'(count <= 3'd1), 32'd1);
        drain();
        chk("t3_no_ovf", 32'(overflow), 32'd0);

        // Test 4: fill, drop, full-with-pop, clear.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            smp(1'b1, xs(k), qs(k), 1'b0, 1'b0);
            if (k >= 4 && k <= 7) exp_q.push_back({xs(k - 3), qs(k)});
        end
        settle(1'b0);
        chk("t4_full_count", 32'(count), 32'd4);
        chk("t4_ovf_set", 32'(overflow), 32'd1);
        smp(1'b1, xs(9), qs(9), 1'b1, 1'b0);
        exp_q.push_back({xs(6), qs(9)});
        settle(1'b0);
        chk("t4_push_pop_count", 32'(count), 32'd4);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        chk("t4_head_i", 32'(dif.out_i), 32'(xs(2)));
        smp(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        settle(1'b0);
        chk("t4_ovf_clr", 32'(overflow), 32'd0);

        // Test 5: clear in the same cycle as a dropped push.
        smp(1'b1, xs(10), qs(10), 1'b0, 1'b1);
        settle(1'b0);
        chk("t5_ovf_set_wins", 32'(overflow), 32'd1);
        chk("t5_count", 32'(count), 32'd4);
        drain();

        // Test 6: asynchronous reset mid-stream.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            smp(1'b1, xs(k), qs(k), 1'b0, 1'b0);
        end
        settle(1'b0);
        chk("t6_pre_count", 32'(count), 32'd3);
        @(posedge clk);
        #3;
        rst_cnt = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_async_valid", 32'(dif.out_valid), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        #2;
        rst_cnt = 1'b1;
        for (int k = 21; k <= 23; k++) begin
            smp(1'b1, xs(k), qs(k), 1'b0, 1'b0);
        end
        settle(1'b0);
        chk("t6_reprime_count", 32'(count), 32'd0);
        smp(1'b1, xs(24), qs(24), 1'b0, 1'b0);
        exp_q.push_back({xs(21), qs(24)});
        settle(1'b0);
        chk("t6_count", 32'(count), 32'd1);
        chk("t6_head_i", 32'(dif.out_i), 32'(xs(21)));
        chk("t6_head_q", 32'(dif.out_q), 32'(qs(24)));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
